// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
// Waits for a rising edge on a source FIFO full flag and then streams NUM_CH frames of
// FRAME_LEN samples from the show-ahead FIFO into an Avalon-ST FFT sink. An optional idle
// delay comes before the first frame, and optional idle gaps come between frames.
//
// Ports
//   clk, rst         : rising-edge clock and synchronous active-high reset
//   fifo_full        : source FIFO full flag; its rising edge is the trigger
//   fifo_empty       : source FIFO empty flag
//   fifo_q           : show-ahead FIFO head word
//   fifo_rdreq       : FIFO pop; asserted only on an accepted sink transfer
//   sink_ready       : FFT core backpressure
//   sink_valid/sop/eop, sink_data, sink_channel : Avalon-ST framing to the FFT core
//   busy             : high whenever the sequencer is not idle
//   frame_done       : one-cycle pulse after the last channel's eop transfer
//   underrun         : sticky; the FIFO ran empty while streaming
//   trig_lost        : sticky; a trigger arrived while busy
module fft_frame_sequencer #(
    parameter int unsigned FRAME_LEN   = 512,
    parameter int unsigned NUM_CH      = 1,
    parameter int unsigned START_DELAY = 0,
    parameter int unsigned GAP_CYC     = 0,
    parameter int unsigned DATA_W      = 16,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_rdreq,
    input  logic              sink_ready,
    output logic              sink_valid,
    output logic              sink_sop,
    output logic              sink_eop,
    output logic [DATA_W-1:0] sink_data,
    output logic [CH_W-1:0]   sink_channel,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun,
    output logic              trig_lost
);

    localparam int unsigned IDX_W = $clog2(FRAME_LEN);
    localparam int unsigned CNT_W = 10;

    localparam logic [IDX_W-1:0] IdxLast   = IDX_W'(FRAME_LEN - 1);
    localparam logic [CH_W-1:0]  ChLast    = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] DelayLast = (START_DELAY > 0) ? CNT_W'(START_DELAY - 1) : '0;
    localparam logic [CNT_W-1:0] GapLast   = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

    typedef enum logic [1:0] {StIdle, StDelay, StStream, StGap} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q;
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;
    logic             trig_lost_q, trig_lost_d;
    logic             trigger;
    logic             xfer;

    // full_q resets high so a FIFO already full at reset release is not a trigger.
    assign trigger = fifo_full & ~full_q;

    assign sink_valid   = (state_q == StStream) & ~fifo_empty;
    assign xfer         = sink_valid & sink_ready;
    assign fifo_rdreq   = xfer;
    assign sink_data    = fifo_q;
    assign sink_sop     = sink_valid & (idx_q == '0);
    assign sink_eop     = sink_valid & (idx_q == IdxLast);
    assign sink_channel = ch_q;
    assign busy         = (state_q != StIdle);
    assign frame_done   = done_q;
    assign underrun     = underrun_q;
    assign trig_lost    = trig_lost_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        underrun_d  = underrun_q;
        trig_lost_d = trig_lost_q;

        if (trigger && (state_q != StIdle)) begin
            trig_lost_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    underrun_d  = 1'b0;
                    trig_lost_d = 1'b0;
                    ch_d        = '0;
                    idx_d       = '0;
                    cnt_d       = '0;
                    if (START_DELAY > 0) begin
                        state_d = StDelay;
                    end else begin
                        state_d = StStream;
                    end
                end
            end
            StDelay: begin
                if (cnt_q == DelayLast) begin
                    state_d = StStream;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStream: begin
                if (fifo_empty) begin
                    underrun_d = 1'b1;
                end
                if (xfer) begin
                    if (idx_q == IdxLast) begin
                        idx_d = '0;
                        if (ch_q == ChLast) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            ch_d  = ch_q + 1'b1;
                            cnt_d = '0;
                            if (GAP_CYC > 0) begin
                                state_d = StGap;
                            end else begin
                                state_d = StStream;
                            end
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StStream;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            ch_q        <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b1;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            trig_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            full_q      <= fifo_full;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            trig_lost_q <= trig_lost_d;
        end
    end

endmodule
